mem_lsu: RTL

Load/store unit that sits directly upstream of the byte-addressable data memory and drives its read and write ports.
- Accepts one load or store request at a time from the core over a valid/ready handshake.
- Checks the request for alignment, range and opcode errors.
- Issues the memory access, then formats the load data with sign or zero extension.
- Returns a single registered response over a valid/ready handshake.

---
 rtl/mem_lsu.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Load/store unit between the core and a byte-addressable data memory.
// One request in flight: check, access memory, extend load data, respond.
module mem_lsu #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] adrs_rd,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [3:0]        byt_en,
    output logic [ADDR_W-1:0] adrs_wr,
    output logic [31:0]       wr_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state, state_nxt;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic              accept;
    logic              bad_op, misaligned, out_of_range, req_fault;
    logic [2:0]        size_m1;
    logic [ADDR_W:0]   last_byte;
    logic [3:0]        lane_mask;
    logic [31:0]       load_ext;

    assign accept = req_valid && req_ready;

    // Request checks; the last-byte sum carries one extra bit so addresses near the top never wrap.
    always_comb begin
        // NOTE: defaults first on every combinational output so no path infers a latch.
        bad_op     = 1'b0;
        misaligned = 1'b0;
        size_m1    = 3'd0;
        case (req_funct3)
            3'b000, 3'b100: size_m1 = 3'd0;
            3'b001, 3'b101: begin
                size_m1    = 3'd1;
                misaligned = req_addr[0];
            end
            3'b010: begin
                size_m1    = 3'd3;
                misaligned = |req_addr[1:0];
            end
            default: bad_op = 1'b1;
        endcase
        if (req_we && req_funct3[2]) bad_op = 1'b1;
        last_byte    = {1'b0, req_addr} + (ADDR_W+1)'(size_m1);
        out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);
        req_fault    = bad_op | misaligned | out_of_range;
    end

    always_comb begin
        case (lat_f3)
            3'b000:  load_ext = {{24{rd_data[7]}}, rd_data[7:0]};
            3'b001:  load_ext = {{16{rd_data[15]}}, rd_data[15:0]};
            3'b100:  load_ext = {24'd0, rd_data[7:0]};
            3'b101:  load_ext = {16'd0, rd_data[15:0]};
            default: load_ext = rd_data;
        endcase
    end

    always_comb begin
        case (lat_f3[1:0])
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_fault ? RESP : (req_we ? WRITE : READ);
            READ:  state_nxt = RESP;
            WRITE: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
        else     state <= state_nxt;
    end

    // Faults and stores answer with zero data; loads overwrite it during READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                rdata_q   <= 32'd0;
                fault_q   <= req_fault;
            end
            if (state == READ) rdata_q <= load_ext;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
    assign adrs_rd   = lat_addr;
    assign adrs_wr   = lat_addr;
    assign wr_en     = (state == WRITE) && lat_we;
    assign byt_en    = wr_en ? lane_mask : 4'b0000;
    assign wr_data   = lat_wdata & {{8{byt_en[3]}}, {8{byt_en[2]}}, {8{byt_en[1]}}, {8{byt_en[0]}}};

endmodule
